ioctl_mem_arb: RTL and testbench

- Shares one synchronous single-port RAM between the core CPU and the hps_io file-download/erase write stream (ioctl_wr/ioctl_addr/ioctl_dout).
- Buffers ioctl writes in a small FIFO so no write pulse is lost while a CPU access is in flight.
- Holds the CPU off while a download or erase is active, then returns the RAM to it.
- Sits between hps_io, the CPU bus and the main RAM instance in the core top level.

---
 rtl/ioctl_mem_arb.sv | 156 +++++++++++++++
 tb/tb_ioctl_mem_arb.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_mem_arb.sv
// Arbitrates one single-port RAM between the CPU bus and the hps_io download/erase
// write stream, buffering ioctl writes in a small FIFO that always wins over the CPU.
module ioctl_mem_arb #(
    parameter int AW         = 25,
    parameter int DW         = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ioctl_download,
    input  logic          ioctl_erasing,
    input  logic          ioctl_wr,
    input  logic [AW-1:0] ioctl_addr,
    input  logic [DW-1:0] ioctl_dout,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic [DW-1:0] cpu_dout,
    output logic          cpu_ack,
    output logic          cpu_hold,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_ce,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic          ioctl_ovf
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, IO_ACC, CPU_ACC, RD_LAT} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] cpu_dout_q, cpu_dout_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          cpu_hold_q, cpu_hold_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_ce_q, mem_ce_d;
    logic          mem_we_q, mem_we_d;
    logic          ioctl_ovf_q, ioctl_ovf_d;

    logic [AW-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DW-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          fifo_empty, fifo_full, pop, push;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign pop        = (state_q == IDLE) && !fifo_empty;
    // A pop in the same cycle frees a slot, so a push against a full FIFO still lands.
    assign push       = ioctl_wr && (!fifo_full || pop);

    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d     = count_q;
        if (push && !pop) count_d = count_q + CW'(1);
        if (pop && !push) count_d = count_q - CW'(1);
        ioctl_ovf_d = ioctl_ovf_q | (ioctl_wr & fifo_full & ~pop);
        cpu_hold_d  = ioctl_download | ioctl_erasing | ~fifo_empty;
    end

    always_comb begin
        state_d     = state_q;
        cpu_dout_d  = cpu_dout_q;
        cpu_ack_d   = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_ce_d    = 1'b0;
        mem_we_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    mem_addr_d  = fifo_addr_q[rd_ptr_q];
                    mem_wdata_d = fifo_data_q[rd_ptr_q];
                    mem_ce_d    = 1'b1;
                    mem_we_d    = 1'b1;
                    state_d     = IO_ACC;
                end else if (cpu_req && !cpu_hold_q && !cpu_ack_q) begin
                    mem_addr_d  = cpu_addr;
                    mem_wdata_d = cpu_din;
                    mem_ce_d    = 1'b1;
                    mem_we_d    = cpu_we;
                    state_d     = CPU_ACC;
                end
            end
            IO_ACC: state_d = IDLE;
            CPU_ACC: begin
                if (mem_we_q) begin
                    cpu_ack_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d   = RD_LAT;
                end
            end
            RD_LAT: begin
                cpu_dout_d = mem_rdata;
                cpu_ack_d  = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cpu_dout_q  <= '0;
            cpu_ack_q   <= 1'b0;
            cpu_hold_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_ce_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            ioctl_ovf_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            cpu_dout_q  <= cpu_dout_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_hold_q  <= cpu_hold_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_ce_q    <= mem_ce_d;
            mem_we_q    <= mem_we_d;
            ioctl_ovf_q <= ioctl_ovf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= ioctl_addr;
            fifo_data_q[wr_ptr_q] <= ioctl_dout;
        end
    end

    assign cpu_dout  = cpu_dout_q;
    assign cpu_ack   = cpu_ack_q;
    assign cpu_hold  = cpu_hold_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_ce    = mem_ce_q;
    assign mem_we    = mem_we_q;
    assign ioctl_ovf = ioctl_ovf_q;

endmodule

// File: tb/tb_ioctl_mem_arb.sv
// Directed bench for ioctl_mem_arb: CPU access latency, download bursts,
// contention, FIFO full/overflow and asynchronous reset, against a small RAM model.
module tb_ioctl_mem_arb;
    localparam int AW = 25;
    localparam int DW = 8;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic          ioctl_download = 1'b0;
    logic          ioctl_erasing = 1'b0;
    logic          ioctl_wr = 1'b0;
    logic [AW-1:0] ioctl_addr = '0;
    logic [DW-1:0] ioctl_dout = '0;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_din = '0;
    logic [DW-1:0] cpu_dout;
    logic          cpu_ack;
    logic          cpu_hold;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ce;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic          ioctl_ovf;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0]    ram [0:1023];
    logic [AW+DW-1:0] wr_log [$];

    ioctl_mem_arb #(.AW(AW), .DW(DW), .FIFO_DEPTH(4)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .ioctl_download(ioctl_download), .ioctl_erasing(ioctl_erasing),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_ack(cpu_ack), .cpu_hold(cpu_hold),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ce(mem_ce), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .ioctl_ovf(ioctl_ovf)
    );

    always #5 clk_sys = ~clk_sys;

    // Synchronous RAM: read data appears the cycle after the strobe; every write is logged in order.
    always @(posedge clk_sys) begin
        if (mem_ce) begin
            if (mem_we) begin
                ram[mem_addr[9:0]] <= mem_wdata;
                wr_log.push_back({mem_addr, mem_wdata});
            end else begin
                mem_rdata <= ram[mem_addr[9:0]];
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] din);
        cpu_req  = req;
        cpu_we   = we;
        cpu_addr = addr;
        cpu_din  = din;
    endtask

    task automatic checkLogEntry(input string tag, input int idx, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        logic [AW+DW-1:0] obs;
        obs = (idx < wr_log.size()) ? wr_log[idx] : 'x;
        checkOutput(tag, 64'(obs), 64'({addr, data}));
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        checkOutput("rst_mem_ce", mem_ce, 1'b0);
        checkOutput("rst_mem_we", mem_we, 1'b0);
        checkOutput("rst_ack", cpu_ack, 1'b0);
        checkOutput("rst_hold", cpu_hold, 1'b0);
        checkOutput("rst_ovf", ioctl_ovf, 1'b0);
        checkOutput("rst_addr", 64'(mem_addr), 64'(0));
        checkOutput("rst_dout", 64'(cpu_dout), 64'(0));
        reset_n = 1'b1;
        tick();

        // CPU write 0xA5 to 0x123; request stays high through the ack cycle
        applyStimulus(1'b1, 1'b1, 25'h000123, 8'hA5);
        tick();
        checkOutput("cw_ce", mem_ce, 1'b1);
        checkOutput("cw_we", mem_we, 1'b1);
        checkOutput("cw_addr", 64'(mem_addr), 64'h123);
        checkOutput("cw_wdata", 64'(mem_wdata), 64'hA5);
        checkOutput("cw_ack_c1", cpu_ack, 1'b0);
        tick();
        checkOutput("cw_ack_c2", cpu_ack, 1'b1);
        checkOutput("cw_ce_c2", mem_ce, 1'b0);
        tick();
        checkOutput("cw_no_regrant", mem_ce, 1'b0);
        checkOutput("cw_ack_clr", cpu_ack, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, '0);
        checkOutput("cw_log_n", 64'(wr_log.size()), 64'(1));
        checkLogEntry("cw_log0", 0, 25'h000123, 8'hA5);
        wr_log.delete();
        tick();

        // CPU read back from 0x123
        applyStimulus(1'b1, 1'b0, 25'h000123, 8'h00);
        tick();
        checkOutput("cr_ce", mem_ce, 1'b1);
        checkOutput("cr_we", mem_we, 1'b0);
        tick();
        checkOutput("cr_ack_c2", cpu_ack, 1'b0);
        tick();
        checkOutput("cr_ack_c3", cpu_ack, 1'b1);
        checkOutput("cr_dout", 64'(cpu_dout), 64'hA5);
        applyStimulus(1'b0, 1'b0, '0, '0);
        tick();
        checkOutput("cr_ack_clr", cpu_ack, 1'b0);
        checkOutput("cr_dout_held", 64'(cpu_dout), 64'hA5);

        // Download burst: 8 writes, one every 4 cycles
        ioctl_download = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = AW'(32'h100 + i);
            ioctl_dout = DW'(8'h30 + i);
            tick();
            ioctl_wr = 1'b0;
            checkOutput($sformatf("dl_hold%0d", i), cpu_hold, 1'b1);
            tick();
            tick();
            tick();
        end
        tick();
        ioctl_download = 1'b0;
        checkOutput("dl_ovf", ioctl_ovf, 1'b0);
        checkOutput("dl_log_n", 64'(wr_log.size()), 64'(8));
        for (int i = 0; i < 8; i++)
            checkLogEntry($sformatf("dl_log%0d", i), i, AW'(32'h100 + i), DW'(8'h30 + i));
        tick();
        tick();
        checkOutput("dl_hold_drop", cpu_hold, 1'b0);
        wr_log.delete();

        // Contention: CPU read granted in the same cycle an ioctl write arrives
        applyStimulus(1'b1, 1'b0, 25'h000100, 8'h00);
        ioctl_download = 1'b1;
        ioctl_wr       = 1'b1;
        ioctl_addr     = 25'h000200;
        ioctl_dout     = 8'h77;
        tick();
        ioctl_wr = 1'b0;
        checkOutput("ct_cpu_ce", mem_ce, 1'b1);
        checkOutput("ct_cpu_we", mem_we, 1'b0);
        checkOutput("ct_cpu_addr", 64'(mem_addr), 64'h100);
        checkOutput("ct_hold_c1", cpu_hold, 1'b1);
        tick();
        tick();
        checkOutput("ct_ack", cpu_ack, 1'b1);
        checkOutput("ct_dout", 64'(cpu_dout), 64'h30);
        applyStimulus(1'b0, 1'b0, '0, '0);
        tick();
        checkOutput("ct_io_ce", mem_ce, 1'b1);
        checkOutput("ct_io_we", mem_we, 1'b1);
        checkOutput("ct_io_addr", 64'(mem_addr), 64'h200);
        checkOutput("ct_io_data", 64'(mem_wdata), 64'h77);
        checkOutput("ct_hold_c4", cpu_hold, 1'b1);
        ioctl_download = 1'b0;
        tick();
        checkOutput("ct_hold_drop", cpu_hold, 1'b0);
        checkOutput("ct_ce_done", mem_ce, 1'b0);
        wr_log.delete();
        tick();

        // Back-to-back writes: the 8th push meets a full FIFO with a pop (accepted),
        // the 9th meets it full with no pop (dropped), the 10th is accepted again
        ioctl_download = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = AW'(32'h300 + i);
            ioctl_dout = DW'(8'h50 + i);
            tick();
            if (i == 7) checkOutput("full_pushpop_ovf", ioctl_ovf, 1'b0);
            if (i == 8) checkOutput("ovf_set", ioctl_ovf, 1'b1);
        end
        ioctl_wr = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        ioctl_download = 1'b0;
        tick();
        tick();
        checkOutput("ovf_sticky", ioctl_ovf, 1'b1);
        checkOutput("ovf_log_n", 64'(wr_log.size()), 64'(9));
        for (int i = 0; i < 8; i++)
            checkLogEntry($sformatf("ovf_log%0d", i), i, AW'(32'h300 + i), DW'(8'h50 + i));
        checkLogEntry("ovf_log8", 8, 25'h000309, 8'h59);
        checkOutput("ovf_hold_drop", cpu_hold, 1'b0);

        // Reset in the middle of a CPU read
        applyStimulus(1'b1, 1'b0, 25'h000300, 8'h00);
        tick();
        checkOutput("mr_ce", mem_ce, 1'b1);
        reset_n = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0);
        #1;
        checkOutput("mr_ce_async", mem_ce, 1'b0);
        checkOutput("mr_ovf_clr", ioctl_ovf, 1'b0);
        tick();
        checkOutput("mr_ce_edge", mem_ce, 1'b0);
        checkOutput("mr_ack_edge", cpu_ack, 1'b0);
        reset_n = 1'b1;
        tick();
        tick();
        checkOutput("mr_no_ack", cpu_ack, 1'b0);
        checkOutput("mr_idle_ce", mem_ce, 1'b0);
        checkOutput("mr_fifo_empty", cpu_hold, 1'b0);
        applyStimulus(1'b1, 1'b1, 25'h0003FF, 8'h3C);
        tick();
        checkOutput("mr_regrant_ce", mem_ce, 1'b1);
        checkOutput("mr_regrant_addr", 64'(mem_addr), 64'h3FF);
        tick();
        checkOutput("mr_regrant_ack", cpu_ack, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, '0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
